// File: rtl/led_pkg.sv
// Shared types and constants for the LED serial output path.
package led_pkg;

    localparam int unsigned LED_WIDTH = 16;
    localparam int unsigned SER_DIV   = 4;
    // Divider count width; covers DIV values up to 255.
    localparam int unsigned DIV_W     = 8;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        LATCH
    } state_t;

    // Registered pins driving the 74HC595 chain.
    typedef struct packed {
        logic clk;
        logic data;
        logic latch;
    } ser_bus_t;

endpackage

// File: rtl/ser_tick_gen.sv
// Phase divider: counts 0..DIV-1 and flags the last cycle of each phase.
module ser_tick_gen
    import led_pkg::*;
#(
    parameter int unsigned DIV = SER_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CW = DIV_W;

    logic [CW-1:0] cnt;

    assign tick_c = (cnt == CW'(DIV - 1));

    // Count up, restarting on clear or at the end of each phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/led_shift_out.sv
// Shifts a frame MSB-first into a 74HC595 chain, then pulses the storage latch.
module led_shift_out
    import led_pkg::*;
#(
    parameter int unsigned WIDTH = LED_WIDTH,
    parameter int unsigned DIV   = SER_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] frame,
    output logic             busy,
    output logic             done,
    output logic             ser_clk,
    output logic             ser_data,
    output logic             ser_latch
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_nxt;
    logic             pend_v;
    logic             pend_v_nxt;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] bcnt_nxt;
    logic             done_nxt;
    logic             busy_nxt;
    ser_bus_t         bus_nxt;
    ser_bus_t         bus_q;
    logic             tick_c;
    logic             div_clr_c;
    logic             exit_c;

    // Divider restarts on every state change and is held clear while idle.
    assign div_clr_c = (state_nxt != state) || (state == IDLE);

    ser_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr    (div_clr_c),
        .tick_c (tick_c)
    );

    // Last cycle of the latch phase: the transfer ends here.
    assign exit_c = (state == LATCH) && tick_c;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_nxt  = state;
        sreg_nxt   = sreg;
        pend_nxt   = pend;
        pend_v_nxt = pend_v;
        bcnt_nxt   = bcnt;
        done_nxt   = 1'b0;

        // A load mid-transfer parks in the single pending slot; newest wins.
        if (load && (state != IDLE) && !exit_c) begin
            pend_nxt   = frame;
            pend_v_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                if (load) begin
                    sreg_nxt  = frame;
                    bcnt_nxt  = CNT_W'(WIDTH);
                    state_nxt = LO;
                end
            end
            LO: begin
                if (tick_c) begin
                    state_nxt = HI;
                end
            end
            HI: begin
                if (tick_c) begin
                    sreg_nxt  = sreg << 1;
                    bcnt_nxt  = bcnt - CNT_W'(1);
                    state_nxt = (bcnt == CNT_W'(1)) ? LATCH : LO;
                end
            end
            LATCH: begin
                if (tick_c) begin
                    done_nxt = 1'b1;
                    if (load) begin
                        // Exit-cycle load takes priority and discards any pending frame.
                        sreg_nxt   = frame;
                        bcnt_nxt   = CNT_W'(WIDTH);
                        pend_v_nxt = 1'b0;
                        state_nxt  = LO;
                    end else if (pend_v) begin
                        sreg_nxt   = pend;
                        bcnt_nxt   = CNT_W'(WIDTH);
                        pend_v_nxt = 1'b0;
                        state_nxt  = LO;
                    end else begin
                        state_nxt  = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered pins track the state.
        busy_nxt      = (state_nxt != IDLE);
        bus_nxt.clk   = (state_nxt == HI);
        bus_nxt.data  = sreg_nxt[WIDTH-1];
        bus_nxt.latch = (state_nxt == LATCH);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sreg   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            bcnt   <= '0;
        end else begin
            state  <= state_nxt;
            sreg   <= sreg_nxt;
            pend   <= pend_nxt;
            pend_v <= pend_v_nxt;
            bcnt   <= bcnt_nxt;
        end
    end

    // Output registers; reset drops the latch so the LEDs keep the last full frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            bus_q <= '0;
        end else begin
            busy  <= busy_nxt;
            done  <= done_nxt;
            bus_q <= bus_nxt;
        end
    end

    assign ser_clk   = bus_q.clk;
    assign ser_data  = bus_q.data;
    assign ser_latch = bus_q.latch;

endmodule

// File: tb/tb_led_shift_out.sv
// Randomised and directed bench for led_shift_out against a transaction-level model.
module tb_led_shift_out;
    import led_pkg::*;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int TS = 2 * D * W;
    localparam int L  = TS + D;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          load  = 1'b0;
    logic [W-1:0]  frame = '0;

    logic busy, done, ser_clk, ser_data, ser_latch;
    logic busy1, done1, ser_clk1, ser_data1, ser_latch1;

    always #5 clk = ~clk;

    led_shift_out #(.WIDTH(W), .DIV(D)) u_dut (
        .clk(clk), .rst(rst), .load(load), .frame(frame),
        .busy(busy), .done(done), .ser_clk(ser_clk),
        .ser_data(ser_data), .ser_latch(ser_latch)
    );

    led_shift_out #(.WIDTH(W), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .load(load), .frame(frame),
        .busy(busy1), .done(done1), .ser_clk(ser_clk1),
        .ser_data(ser_data1), .ser_latch(ser_latch1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Transaction-level model: a transfer lasts L cycles; one pending slot.
    bit           m_act  = 0;
    bit           m_done = 0;
    bit           m_pv   = 0;
    int           m_t    = 0;
    logic [W-1:0] m_f    = '0;
    logic [W-1:0] m_p    = '0;
    logic [W-1:0] m_started[$];

    task automatic m_start(input logic [W-1:0] f);
        m_act = 1;
        m_t   = 0;
        m_f   = f;
        m_started.push_back(f);
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_act = 0; m_done = 0; m_pv = 0; m_t = 0;
        end else begin
            m_done = 0;
            if (!m_act) begin
                if (load) m_start(frame);
            end else if (m_t == L - 1) begin
                m_done = 1;
                if (load) begin
                    m_start(frame);
                    m_pv = 0;
                end else if (m_pv) begin
                    m_start(m_p);
                    m_pv = 0;
                end else begin
                    m_act = 0;
                end
            end else begin
                m_t++;
                if (load) begin
                    m_p  = frame;
                    m_pv = 1;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model's timeline.
    logic [4:0] e;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            e[4] = m_act;
            e[3] = m_done;
            if (m_act && m_t < TS) begin
                e[2] = ((m_t / D) % 2) == 1;
                e[1] = m_f[W - 1 - m_t / (2 * D)];
                e[0] = 1'b0;
            end else begin
                e[2] = 1'b0;
                e[1] = 1'b0;
                e[0] = m_act;
            end
            chk("cycle busy/done/sclk/sdata/latch",
                32'({busy, done, ser_clk, ser_data, ser_latch}), 32'(e));
        end
    end

    // Stream decoder: rebuilds each latched word from ser_clk rises.
    logic [W-1:0] dec_bits = '0;
    int           dec_nb   = 0;
    logic         dec_pc   = 1'b0;
    logic         dec_pl   = 1'b0;
    logic [W-1:0] sent[$];
    int           sent_nb[$];

    initial forever begin
        @(negedge clk or negedge rst);
        if (!rst) begin
            dec_nb = 0; dec_pc = 1'b0; dec_pl = 1'b0;
        end else begin
            if (ser_clk && !dec_pc) begin
                dec_bits = {dec_bits[W-2:0], ser_data};
                dec_nb++;
            end
            if (ser_latch && !dec_pl) begin
                sent.push_back(dec_bits);
                sent_nb.push_back(dec_nb);
                dec_nb = 0;
            end
            dec_pc = ser_clk;
            dec_pl = ser_latch;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [W-1:0] f);
        load  = 1'b1;
        frame = f;
        @(negedge clk);
        load  = 1'b0;
        frame = W'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        while ((busy || m_act) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 32'(busy), 32'(0));
    endtask

    initial begin
        logic [W-1:0] bits1;
        int           nrise, lat, done_at, nb, nlat, bad, i;
        logic         prev;

        step(3);
        chk("reset outs", 32'({busy, done, ser_clk, ser_data, ser_latch}), 32'(0));
        chk("reset outs div1", 32'({busy1, done1, ser_clk1, ser_data1, ser_latch1}), 32'(0));
        rst = 1'b1;
        step(2);

        // Single transfer at DIV=1.
        bits1 = '0; nrise = 0; lat = 0; done_at = -1; prev = 1'b0;
        do_load(16'hA5C3);
        for (int c = 0; c < 60 && done_at < 0; c++) begin
            if (ser_clk1 && !prev) begin
                bits1 = {bits1[W-2:0], ser_data1};
                nrise++;
            end
            if (ser_latch1) lat++;
            if (done1) done_at = c;
            prev = ser_clk1;
            @(negedge clk);
        end
        chk("div1 serial bits", 32'(bits1), 32'(16'hA5C3));
        chk("div1 clk rises", 32'(nrise), 32'(16));
        chk("div1 latch cycles", 32'(lat), 32'(1));
        chk("div1 done cycle", 32'(done_at), 32'(33));
        wait_idle("idle after A5C3", 400);

        // Default divider, all ones.
        sent.delete(); sent_nb.delete();
        do_load(16'hFFFF);
        nb = 0; nlat = 0;
        while (busy && nb < 300) begin
            nb++;
            if (ser_latch) nlat++;
            @(negedge clk);
        end
        chk("busy length", 32'(nb), 32'(132));
        chk("latch length", 32'(nlat), 32'(4));
        chk("FFFF sent", 32'(sent[0]), 32'(16'hFFFF));
        chk("FFFF rises", 32'(sent_nb[0]), 32'(16));

        // Pending overwrite, back-to-back.
        step(3);
        sent.delete(); sent_nb.delete();
        do_load(16'h1234);
        step(10);
        do_load(16'h0001);
        step(20);
        do_load(16'h8000);
        wait_idle("idle after overwrite", 2 * L + 50);
        chk("overwrite count", 32'(sent.size()), 32'(2));
        chk("overwrite first", 32'(sent[0]), 32'(16'h1234));
        chk("overwrite second", 32'(sent[1]), 32'(16'h8000));

        // Load on the latch exit cycle beats the pending frame.
        step(3);
        sent.delete(); sent_nb.delete();
        do_load(16'hAAAA);
        step(5);
        do_load(16'h00FF);
        i = 0;
        while (!(m_act && m_t == L - 1) && i < 300) begin
            @(negedge clk);
            i++;
        end
        chk("exit cycle reached", 32'(i < 300), 32'(1));
        do_load(16'hF0F0);
        wait_idle("idle after collision", 2 * L + 50);
        chk("collision count", 32'(sent.size()), 32'(2));
        chk("collision first", 32'(sent[0]), 32'(16'hAAAA));
        chk("collision second", 32'(sent[1]), 32'(16'hF0F0));

        // Random loads; latched words must match the model's started frames.
        step(3);
        sent.delete(); sent_nb.delete(); m_started.delete();
        for (int k = 0; k < 40; k++) begin
            step($urandom_range(0, 150));
            do_load(W'($urandom));
        end
        wait_idle("idle after random", 3 * L);
        chk("random count", 32'(sent.size()), 32'(m_started.size()));
        for (int k = 0; k < m_started.size() && k < sent.size(); k++) begin
            chk("random word", 32'(sent[k]), 32'(m_started[k]));
            chk("random rises", 32'(sent_nb[k]), 32'(16));
        end

        // Reset after the 7th serial clock rise, with a frame pending.
        step(3);
        sent.delete(); sent_nb.delete();
        do_load(16'h1357);
        step(3);
        do_load(16'h2468);
        i = 0;
        while (dec_nb < 7 && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk("7th rise seen", 32'(dec_nb), 32'(7));
        #2 rst = 1'b0;
        #1 chk("async reset outs", 32'({busy, done, ser_clk, ser_data, ser_latch}), 32'(0));
        chk("async reset outs div1", 32'({busy1, done1, ser_clk1, ser_data1, ser_latch1}), 32'(0));
        step(4);
        chk("held reset outs", 32'({busy, done, ser_clk, ser_data, ser_latch}), 32'(0));
        rst = 1'b1;
        step(2 * L);
        chk("no latch after reset", 32'(sent.size()), 32'(0));
        do_load(16'h0F0F);
        wait_idle("idle after 0F0F", 400);
        chk("post-reset count", 32'(sent.size()), 32'(1));
        chk("post-reset word", 32'(sent[0]), 32'(16'h0F0F));

        // Idle stability.
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (busy || ser_clk || ser_latch || done) bad++;
        end
        chk("idle activity", 32'(bad), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
